fetch_if_id_stage: RTL
======================

Name: fetch_if_id_stage

Overview:
- PC/nPC generation and IF/ID pipeline register for the SPARC pipeline, directly upstream of the decode-stage operand2 source handler.
- Drives the instruction-memory address and latches the fetched word.
- Presents the latched instruction plus pre-split fields (imm22, operand-select bits) to decode.
- Implements SPARC delayed control transfer, with stall, flush and delay-slot annul.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0100_0000, word injected on bubble/annul/flush (sethi 0,%g0)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
le  input  1  load enable; 0 = stall, all state holds
inst_in  input  32  word returned by instruction memory for address pc_out (same cycle)
branch_taken  input  1  CTI resolved taken; nPC is redirected to target_addr
target_addr  input  32  CTI target, word aligned
annul_slot  input  1  annul the delay-slot instruction being latched this cycle
flush  input  1  squash the IF/ID contents (trap/exception)
pc_out  output  32  current fetch PC, to instruction memory
npc_out  output  32  current nPC
id_instr  output  32  latched instruction to decode (IS of operand2 handler)
id_pc  output  32  PC of id_instr
id_valid  output  1  id_instr is a real instruction
id_imm22  output  22  id_instr[21:0]
id_opsel  output  4  {id_instr[31], id_instr[30], id_instr[24], id_instr[13]}

Behaviour:
- Reset (rst_n=0 at edge), dominates all inputs:
  - pc_out=RESET_PC; npc_out=RESET_PC+4
  - id_instr=NOP_WORD; id_pc=0; id_valid=0
  - FSM->BOOT
  - Reset mid-stall or mid-branch discards all pending state.
- FSM states:
  - BOOT: exactly one cycle after reset release. IF/ID is loaded with NOP_WORD and id_valid=0; the PC does not advance. Goes to RUN on the next edge with le=1. If le=0, stays in BOOT.
  - RUN: normal operation.
- RUN, le=1, edge update:
  - PC<=nPC
  - nPC<=branch_taken ? target_addr : nPC+4
  - id_instr<=inst_in; id_pc<=pc_out; id_valid<=1
- Delayed branch: the instruction at old nPC (delay slot) is always fetched the cycle after branch_taken, then fetch continues at target_addr.
- annul_slot=1 with le=1:
  - IF/ID loads NOP_WORD with id_valid=0 instead of inst_in.
  - PC/nPC update normally, as above.
- flush=1 with le=1:
  - IF/ID loads NOP_WORD with id_valid=0.
  - PC<=target_addr; nPC<=target_addr+4; branch_taken is ignored.
- Priority: rst_n > le=0 > flush > branch_taken/annul_slot. annul_slot and branch_taken may be asserted together; both take effect.
- le=0: PC, nPC, IF/ID, FSM all hold. branch_taken, annul_slot and flush are ignored; the upstream holds them until le=1.
- Arithmetic:
  - nPC+4 is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
  - target_addr[1:0] is forced to 00 when loaded.
- Combinational outputs: id_imm22 and id_opsel derive from id_instr only, so zero-latency relative to the register.
- Other outputs are registered; no combinational path from inputs to outputs.
- Latency: inst_in appears on id_instr one edge after it is presented.

Test Plan:
- Reset/boot: hold rst_n=0 for 2 cycles, release with le=1 and RESET_PC=0.
  - After the first edge: pc_out=0, id_valid=0, id_instr=32'h0100_0000.
  - After the second edge: pc_out=4, npc_out=8, id_pc=0, id_valid=1.
- Sequential fetch: inst_in=32'h8200_6005 at pc 0x10 -> next edge id_instr=32'h8200_6005, id_opsel=4'b1001, id_imm22=22'h006005, id_pc=0x10.
- Delayed branch: at PC=0x20, nPC=0x24, assert branch_taken with target_addr=0x100 -> pc_out sequence 0x24 then 0x100; npc_out 0x100 then 0x104.
- Annul: the same branch with annul_slot on the delay-slot cycle -> id_valid=0, id_instr=NOP_WORD for the 0x24 word; the 0x100 word latches with id_valid=1.
- Stall: le=0 for 3 cycles with branch_taken=1 toggling -> pc_out, npc_out, id_* unchanged. Re-enable -> resume at the held values.
- Wrap/flush: nPC=32'hFFFF_FFFC advances to 0. Separately, flush with target_addr=0x83 -> pc_out=0x80, npc_out=0x84, id_valid=0.

Source files
------------

// File: rtl/fetch_if_id_stage.sv
// PC/nPC generation and IF/ID pipeline register for a SPARC-style pipeline.
// Implements delayed control transfer (delay slot always fetched), stall,
// flush and delay-slot annul. A single BOOT cycle after reset fills IF/ID
// with a bubble before fetch starts advancing.
module fetch_if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0100_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        le,
  input  logic [31:0] inst_in,
  input  logic        branch_taken,
  input  logic [31:0] target_addr,
  input  logic        annul_slot,
  input  logic        flush,
  output logic [31:0] pc_out,
  output logic [31:0] npc_out,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic [21:0] id_imm22,
  output logic [3:0]  id_opsel
);

  typedef enum logic {StBoot, StRun} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;

  logic [31:0] target_al;
  logic [31:0] npc_inc;

  // Targets are word aligned; low bits from upstream are dropped.
  assign target_al = {target_addr[31:2], 2'b00};
  assign npc_inc   = npc_q + 32'd4;

  // Next-state: stall holds everything; flush beats branch/annul.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    if (le) begin
      unique case (state_q)
        StBoot: begin
          // Bubble into IF/ID; PC stays put so RESET_PC is fetched next.
          id_instr_d = NOP_WORD;
          id_valid_d = 1'b0;
          state_d    = StRun;
        end
        StRun: begin
          id_pc_d = pc_q;
          if (flush) begin
            pc_d       = target_al;
            npc_d      = target_al + 32'd4;
            id_instr_d = NOP_WORD;
            id_valid_d = 1'b0;
          end else begin
            pc_d  = npc_q;
            npc_d = branch_taken ? target_al : npc_inc;
            if (annul_slot) begin
              id_instr_d = NOP_WORD;
              id_valid_d = 1'b0;
            end else begin
              id_instr_d = inst_in;
              id_valid_d = 1'b1;
            end
          end
        end
        default: state_d = StBoot;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      npc_q      <= RESET_PC + 32'd4;
      id_instr_q <= NOP_WORD;
      id_pc_q    <= 32'h0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign pc_out   = pc_q;
  assign npc_out  = npc_q;
  assign id_instr = id_instr_q;
  assign id_pc    = id_pc_q;
  assign id_valid = id_valid_q;
  assign id_imm22 = id_instr_q[21:0];
  assign id_opsel = {id_instr_q[31], id_instr_q[30], id_instr_q[24], id_instr_q[13]};

endmodule
